// File: rtl/video_pattern_gen.sv
// Video timing and test-pattern generator for the ADV7513 HDMI path.
// Config changes are staged in a shadow register and go live only at the frame boundary.
module video_pattern_gen #(
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic SYNC_POL = 1'b0,
    parameter int   CHK_LOG2 = 5,
    parameter int   BOX_SIZE = 32
) (
    input  logic        pix_clk,
    input  logic        reset_n,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [2:0]  cfg_mode,
    input  logic [23:0] cfg_colour,
    output logic [11:0] hcount,
    output logic [11:0] vcount,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic [23:0] rgb,
    output logic        frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [11:0] H_LAST    = 12'(H_TOT - 1);
    localparam logic [11:0] V_LAST    = 12'(V_TOT - 1);
    localparam logic [11:0] H_ACT_END = 12'(H_ACTIVE);
    localparam logic [11:0] V_ACT_END = 12'(V_ACTIVE);
    localparam logic [11:0] HS_BEG    = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END    = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG    = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] VS_END    = 12'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [11:0] BX_MAX    = 12'(H_ACTIVE - BOX_SIZE);
    localparam logic [11:0] BY_MAX    = 12'(V_ACTIVE - BOX_SIZE);
    localparam logic [12:0] BOX_EXT   = 13'(BOX_SIZE);

    typedef enum logic [0:0] {
        CFG_FREE = 1'b0,
        CFG_HELD = 1'b1
    } cfg_state_t;

    function automatic logic [23:0] bar_colour(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'hffffff;
            3'd1:    c = 24'hffff00;
            3'd2:    c = 24'h00ffff;
            3'd3:    c = 24'h00ff00;
            3'd4:    c = 24'hff00ff;
            3'd5:    c = 24'hff0000;
            3'd6:    c = 24'h0000ff;
            default: c = 24'h000000;
        endcase
        return c;
    endfunction

    logic [11:0] h_r;
    logic [11:0] v_r;
    logic        h_last_s;
    logic        v_last_s;
    logic        frame_end_s;

    cfg_state_t  cfg_state_r;
    cfg_state_t  cfg_state_nxt_s;
    logic        cfg_take_s;
    logic        cfg_apply_s;
    logic        cfg_ready_r;
    logic [2:0]  shadow_mode_r;
    logic [23:0] shadow_colour_r;
    logic [2:0]  live_mode_r;
    logic [23:0] live_colour_r;

    logic [11:0] bx_r;
    logic [11:0] by_r;
    logic        dir_x_r;
    logic        dir_y_r;

    logic        active_s;
    logic        hs_on_s;
    logic        vs_on_s;
    logic [2:0]  bar_idx_s;
    logic        chk_s;
    logic        in_box_s;
    logic [23:0] pix_s;

    logic [11:0] hcount_r;
    logic [11:0] vcount_r;
    logic        de_r;
    logic        hsync_r;
    logic        vsync_r;
    logic [23:0] rgb_r;
    logic        frame_start_r;

    assign h_last_s    = (h_r == H_LAST);
    assign v_last_s    = (v_r == V_LAST);
    assign frame_end_s = h_last_s & v_last_s;

    // Raster position counters
    always_ff @(posedge pix_clk or negedge reset_n) begin
        if (!reset_n) begin
            h_r <= 12'd0;
            v_r <= 12'd0;
        end else if (h_last_s) begin
            h_r <= 12'd0;
            v_r <= v_last_s ? 12'd0 : v_r + 12'd1;
        end else begin
            h_r <= h_r + 12'd1;
        end
    end

    // Shadow-register handshake: FREE accepts an offer, HELD waits for the frame boundary
    always_comb begin
        cfg_state_nxt_s = cfg_state_r;
        cfg_take_s      = 1'b0;
        cfg_apply_s     = 1'b0;
        case (cfg_state_r)
            CFG_FREE: begin
                if (cfg_valid) begin
                    cfg_take_s      = 1'b1;
                    cfg_state_nxt_s = CFG_HELD;
                end else begin
                    cfg_state_nxt_s = CFG_FREE;
                end
            end
            CFG_HELD: begin
                if (frame_end_s) begin
                    cfg_apply_s     = 1'b1;
                    cfg_state_nxt_s = CFG_FREE;
                end else begin
                    cfg_state_nxt_s = CFG_HELD;
                end
            end
            default: cfg_state_nxt_s = CFG_FREE;
        endcase
    end

    // Handshake state, shadow capture and live update
    always_ff @(posedge pix_clk or negedge reset_n) begin
        if (!reset_n) begin
            cfg_state_r     <= CFG_FREE;
            cfg_ready_r     <= 1'b1;
            shadow_mode_r   <= 3'd0;
            shadow_colour_r <= 24'h000000;
            live_mode_r     <= 3'd0;
            live_colour_r   <= 24'h000000;
        end else begin
            cfg_state_r <= cfg_state_nxt_s;
            cfg_ready_r <= (cfg_state_nxt_s == CFG_FREE);
            if (cfg_take_s) begin
                shadow_mode_r   <= cfg_mode;
                shadow_colour_r <= cfg_colour;
            end
            if (cfg_apply_s) begin
                live_mode_r   <= shadow_mode_r;
                live_colour_r <= shadow_colour_r;
            end
        end
    end

    // Box bounces once per frame regardless of the selected pattern
    always_ff @(posedge pix_clk or negedge reset_n) begin
        if (!reset_n) begin
            bx_r    <= 12'd0;
            by_r    <= 12'd0;
            dir_x_r <= 1'b1;
            dir_y_r <= 1'b1;
        end else if (frame_end_s) begin
            if (dir_x_r) begin
                if (bx_r == BX_MAX) begin
                    dir_x_r <= 1'b0;
                    bx_r    <= bx_r - 12'd1;
                end else begin
                    bx_r <= bx_r + 12'd1;
                end
            end else if (bx_r == 12'd0) begin
                dir_x_r <= 1'b1;
                bx_r    <= 12'd1;
            end else begin
                bx_r <= bx_r - 12'd1;
            end
            if (dir_y_r) begin
                if (by_r == BY_MAX) begin
                    dir_y_r <= 1'b0;
                    by_r    <= by_r - 12'd1;
                end else begin
                    by_r <= by_r + 12'd1;
                end
            end else if (by_r == 12'd0) begin
                dir_y_r <= 1'b1;
                by_r    <= 12'd1;
            end else begin
                by_r <= by_r - 12'd1;
            end
        end
    end

    assign active_s = (h_r < H_ACT_END) && (v_r < V_ACT_END);
    assign hs_on_s  = (h_r >= HS_BEG) && (h_r < HS_END);
    assign vs_on_s  = (v_r >= VS_BEG) && (v_r < VS_END);
    assign chk_s    = h_r[CHK_LOG2] ^ v_r[CHK_LOG2];
    assign in_box_s = (h_r >= bx_r) && ({1'b0, h_r} < ({1'b0, bx_r} + BOX_EXT)) &&
                      (v_r >= by_r) && ({1'b0, v_r} < ({1'b0, by_r} + BOX_EXT));

    // Bar index counts how many bar edges h*8 has passed, avoiding a divider
    always_comb begin
        bar_idx_s = 3'd0;
        for (int k = 1; k < 8; k++) begin
            bar_idx_s = bar_idx_s + {2'b00, ({h_r, 3'b000} >= 15'(k * H_ACTIVE))};
        end
    end

    // Pattern select on the live mode
    always_comb begin
        pix_s = 24'h000000;
        case (live_mode_r)
            3'd0:    pix_s = live_colour_r;
            3'd1:    pix_s = bar_colour(bar_idx_s);
            3'd2:    pix_s = chk_s ? 24'h000000 : 24'hffffff;
            3'd3:    pix_s = {3{h_r[7:0]}};
            3'd4:    pix_s = in_box_s ? live_colour_r : 24'h000000;
            default: pix_s = 24'h000000;
        endcase
    end

    // Output stage: one cycle behind the counters, all outputs aligned
    always_ff @(posedge pix_clk or negedge reset_n) begin
        if (!reset_n) begin
            hcount_r      <= 12'd0;
            vcount_r      <= 12'd0;
            de_r          <= 1'b0;
            hsync_r       <= ~SYNC_POL;
            vsync_r       <= ~SYNC_POL;
            rgb_r         <= 24'h000000;
            frame_start_r <= 1'b0;
        end else begin
            hcount_r      <= h_r;
            vcount_r      <= v_r;
            de_r          <= active_s;
            hsync_r       <= hs_on_s ? SYNC_POL : ~SYNC_POL;
            vsync_r       <= vs_on_s ? SYNC_POL : ~SYNC_POL;
            rgb_r         <= active_s ? pix_s : 24'h000000;
            frame_start_r <= (h_r == 12'd0) && (v_r == 12'd0);
        end
    end

    assign cfg_ready   = cfg_ready_r;
    assign hcount      = hcount_r;
    assign vcount      = vcount_r;
    assign de          = de_r;
    assign hsync       = hsync_r;
    assign vsync       = vsync_r;
    assign rgb         = rgb_r;
    assign frame_start = frame_start_r;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Directed bench for video_pattern_gen on a shrunken 40x29 raster (32x24 active).
module tb_video_pattern_gen;

    localparam int HA = 32, HF = 2, HS = 4, HB = 2;
    localparam int VA = 24, VF = 1, VS = 2, VB = 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FR = HT * VT;

    logic        pix_clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic [2:0]  cfg_mode = 3'd0;
    logic [23:0] cfg_colour = 24'h000000;
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        de;
    logic        hsync;
    logic        vsync;
    logic [23:0] rgb;
    logic        frame_start;

    int n_cmp = 0;
    int n_bad = 0;
    int b = -1;

    video_pattern_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .CHK_LOG2(2), .BOX_SIZE(4)
    ) dut (
        .pix_clk(pix_clk), .reset_n(reset_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_mode(cfg_mode), .cfg_colour(cfg_colour),
        .hcount(hcount), .vcount(vcount),
        .de(de), .hsync(hsync), .vsync(vsync),
        .rgb(rgb), .frame_start(frame_start)
    );

    always #5 pix_clk = ~pix_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pix_clk);
        #1;
        b++;
    endtask

    task automatic go(input int f, input int v, input int h);
        while (b < f * FR + v * HT + h) tick();
    endtask

    task automatic pix(input string tag, input int f, input int v, input int h, input logic [23:0] exp);
        go(f, v, h);
        check(tag, {8'h00, rgb}, {8'h00, exp});
    endtask

    task automatic offer(input logic [2:0] m, input logic [23:0] c);
        check("ready_before_offer", {31'd0, cfg_ready}, 32'd1);
        cfg_valid  = 1'b1;
        cfg_mode   = m;
        cfg_colour = c;
        tick();
        cfg_valid  = 1'b0;
    endtask

    initial begin
        int de_cnt, de_l0, hs_lo, first_hs, vs_lo, first_vs, fs_cnt, nz, rdy_hi;
        logic rdy_end;
        logic [11:0] wrap_h, wrap_v;
        de_cnt = 0; de_l0 = 0; hs_lo = 0; first_hs = -1; vs_lo = 0; first_vs = -1;
        fs_cnt = 0; nz = 0; rdy_hi = 0; rdy_end = 1'b0; wrap_h = 12'd0; wrap_v = 12'd0;

        repeat (3) @(posedge pix_clk);
        #1;
        check("rst_de", {31'd0, de}, 32'd0);
        check("rst_hsync", {31'd0, hsync}, 32'd1);
        check("rst_vsync", {31'd0, vsync}, 32'd1);
        check("rst_rgb", {8'h00, rgb}, 32'd0);
        check("rst_fs", {31'd0, frame_start}, 32'd0);
        check("rst_ready", {31'd0, cfg_ready}, 32'd1);
        check("rst_hcount", {20'd0, hcount}, 32'd0);

        reset_n = 1'b1;
        b = -1;
        tick();
        check("b0_fs", {31'd0, frame_start}, 32'd1);
        check("b0_de", {31'd0, de}, 32'd1);
        check("b0_hv", {8'd0, hcount, vcount}, 32'd0);
        check("b0_rgb", {8'h00, rgb}, 32'd0);
        check("b0_hsync", {31'd0, hsync}, 32'd1);

        // Frame 0: gather timing statistics; offer solid 123456 on beat 0
        for (int i = 0; i < FR; i++) begin
            if (de) begin de_cnt++; if (i < HT) de_l0++; end
            if (!hsync) begin hs_lo++; if (first_hs < 0) first_hs = i % HT; end
            if (!vsync) begin vs_lo++; if (first_vs < 0) first_vs = i; end
            if (frame_start) fs_cnt++;
            if (rgb != 24'h0) nz++;
            if (i >= 1 && i <= FR - 2 && cfg_ready) rdy_hi++;
            if (i == FR - 1) rdy_end = cfg_ready;
            if (i == HT) begin wrap_h = hcount; wrap_v = vcount; end
            if (i == 0) begin
                cfg_valid = 1'b1; cfg_mode = 3'd0; cfg_colour = 24'h123456;
            end else begin
                cfg_valid = 1'b0;
            end
            tick();
        end
        check("f0_de_total", de_cnt, 32'd768);
        check("f0_de_line0", de_l0, 32'd32);
        check("f0_hsync_low", hs_lo, 32'd116);
        check("f0_hsync_first", first_hs, 32'd34);
        check("f0_vsync_low", vs_lo, 32'd80);
        check("f0_vsync_first", first_vs, 32'd1000);
        check("f0_fs_count", fs_cnt, 32'd1);
        check("f0_rgb_black", nz, 32'd0);
        check("f0_ready_low", rdy_hi, 32'd0);
        check("f0_ready_end", {31'd0, rdy_end}, 32'd1);
        check("f0_hwrap", {20'd0, wrap_h}, 32'd0);
        check("f0_vstep", {20'd0, wrap_v}, 32'd1);

        check("f1_fs", {31'd0, frame_start}, 32'd1);
        check("f1_de", {31'd0, de}, 32'd1);
        check("f1_rgb", {8'h00, rgb}, 32'h123456);
        pix("f1_solid", 1, 5, 10, 24'h123456);
        go(1, 7, 13);
        check("f1_hv", {8'd0, hcount, vcount}, {8'd0, 12'd13, 12'd7});
        go(1, 8, 0);
        offer(3'd1, 24'h000000);
        check("f1_ready_drop", {31'd0, cfg_ready}, 32'd0);

        pix("bar_h0", 2, 0, 0, 24'hffffff);
        pix("bar_h3", 2, 0, 3, 24'hffffff);
        pix("bar_h4", 2, 0, 4, 24'hffff00);
        pix("bar_h8", 2, 0, 8, 24'h00ffff);
        pix("bar_h12", 2, 0, 12, 24'h00ff00);
        pix("bar_h16", 2, 0, 16, 24'hff00ff);
        pix("bar_h20", 2, 0, 20, 24'hff0000);
        pix("bar_h24", 2, 0, 24, 24'h0000ff);
        pix("bar_h28", 2, 0, 28, 24'h000000);
        pix("bar_h31", 2, 0, 31, 24'h000000);
        pix("bar_hblank", 2, 0, 33, 24'h000000);
        check("bar_hblank_de", {31'd0, de}, 32'd0);
        go(2, 3, 0);
        offer(3'd2, 24'h000000);
        pix("bar_vblank", 2, 26, 5, 24'h000000);
        check("bar_vblank_de", {31'd0, de}, 32'd0);

        pix("chk_3_0", 3, 0, 3, 24'hffffff);
        pix("chk_4_0", 3, 0, 4, 24'h000000);
        pix("chk_0_4", 3, 4, 0, 24'h000000);
        pix("chk_4_4", 3, 4, 4, 24'hffffff);
        go(3, 10, 0);
        offer(3'd0, 24'habcdef);

        pix("f4_solid", 4, 2, 2, 24'habcdef);
        go(4, 10, 5);
        offer(3'd3, 24'habcdef);
        go(4, 20, 0);
        check("f4_ready_mid", {31'd0, cfg_ready}, 32'd0);
        pix("f4_still_solid", 4, 20, 3, 24'habcdef);
        go(4, 28, 38);
        check("f4_ready_last", {31'd0, cfg_ready}, 32'd0);
        tick();
        check("f4_ready_rise", {31'd0, cfg_ready}, 32'd1);

        pix("ramp_h30", 5, 0, 30, 24'h1e1e1e);
        pix("ramp_h7", 5, 3, 7, 24'h070707);
        go(5, 28, 38);
        offer(3'd2, 24'h000000);
        check("edge_ready_low", {31'd0, cfg_ready}, 32'd0);
        pix("edge_still_ramp", 6, 0, 30, 24'h1e1e1e);
        go(6, 28, 39);
        check("edge_ready_rise", {31'd0, cfg_ready}, 32'd1);
        pix("edge_chk_3", 7, 0, 3, 24'hffffff);
        pix("edge_chk_4", 7, 0, 4, 24'h000000);
        go(7, 1, 0);
        offer(3'd4, 24'h00ff00);

        pix("box8_left_out", 8, 8, 7, 24'h000000);
        pix("box8_corner", 8, 8, 8, 24'h00ff00);
        pix("box8_right_out", 8, 8, 12, 24'h000000);
        pix("box8_far_in", 8, 11, 11, 24'h00ff00);
        pix("box8_below_out", 8, 12, 8, 24'h000000);
        pix("box21_above", 21, 18, 21, 24'h000000);
        pix("box21_left", 21, 19, 20, 24'h000000);
        pix("box21_corner", 21, 19, 21, 24'h00ff00);
        pix("box28_corner", 28, 12, 28, 24'h00ff00);
        pix("box28_far", 28, 15, 31, 24'h00ff00);
        pix("box29_above", 29, 10, 27, 24'h000000);
        pix("box29_corner", 29, 11, 27, 24'h00ff00);
        pix("box29_old_edge", 29, 11, 31, 24'h000000);

        go(30, 5, 0);
        offer(3'd1, 24'hffffff);
        go(30, 10, 20);
        reset_n = 1'b0;
        #2;
        check("mid_rst_de", {31'd0, de}, 32'd0);
        check("mid_rst_rgb", {8'h00, rgb}, 32'd0);
        check("mid_rst_hsync", {31'd0, hsync}, 32'd1);
        check("mid_rst_vsync", {31'd0, vsync}, 32'd1);
        check("mid_rst_hv", {8'd0, hcount, vcount}, 32'd0);
        check("mid_rst_ready", {31'd0, cfg_ready}, 32'd1);
        @(posedge pix_clk);
        #1;
        reset_n = 1'b1;
        b = -1;
        tick();
        check("rel_fs", {31'd0, frame_start}, 32'd1);
        check("rel_rgb", {8'h00, rgb}, 32'd0);
        check("rel_ready", {31'd0, cfg_ready}, 32'd1);
        pix("rel_f1_black", 1, 5, 5, 24'h000000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
